// File: rtl/vector_rsv_station.sv
// Vector reservation station for one vector functional unit.
// Buffers dispatched operations and their operand descriptors, wakes operands
// from tagged result broadcasts, and issues the oldest fully-ready entry.
// Optional build macro VRS_SAME_CYCLE_WAKEUP_EN: readiness and selection also
// see this cycle's broadcasts, so an entry woken this cycle can issue at once.
// Without it, out_* depend only on registered state (1-cycle wakeup-to-issue).

package Vector;
  typedef enum logic [2:0] {
    VU_ID_MADD    = 3'd0,
    VU_ID_CMP     = 3'd1,
    VU_ID_LS      = 3'd2,
    VU_ID_PLS     = 3'd3,
    VU_ID_PERMUTE = 3'd4
  } Unit_id;

  typedef struct packed {
    Unit_id     unit;
    logic [3:0] entry;
  } Rs_ref;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
  } Vector_operation;

  typedef struct packed {
    Rs_ref [1:0] src_ref;
    logic  [1:0] required;
    logic  [1:0] valid;
    logic        require_vcr;
    logic        vcr_valid;
  } Operands;
endpackage

module vector_rsv_station #(
  parameter int             DEPTH   = 4,
  parameter Vector::Unit_id UNIT_ID = Vector::VU_ID_MADD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  Vector::Vector_operation in_op,
  input  Vector::Operands         in_opnd,
  output Vector::Rs_ref           alloc_ref,
  input  logic                    wb_valid,
  input  Vector::Rs_ref           wb_ref,
  input  logic                    vcr_wb_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output Vector::Vector_operation out_op,
  output Vector::Operands         out_opnd,
  output Vector::Rs_ref           out_ref
);

  localparam int EW = 4;

  // Apply a broadcast and a condition-register write to one operand record.
  function automatic Vector::Operands wake(input Vector::Operands o,
                                           input logic wv,
                                           input Vector::Rs_ref wr,
                                           input logic vv);
    Vector::Operands r;
    r = o;
    for (int k = 0; k < 2; k++) begin
      if (wv && (o.src_ref[k] == wr) && o.required[k]) r.valid[k] = 1'b1;
    end
    if (vv && o.require_vcr) r.vcr_valid = 1'b1;
    return r;
  endfunction

  logic [DEPTH-1:0]        busy_reg;
  Vector::Vector_operation op_reg    [DEPTH];
  Vector::Operands         opnd_reg  [DEPTH];
  logic [DEPTH-1:0]        older_reg [DEPTH];  // older_reg[i][j]: i allocated before j

  Vector::Operands  woken [DEPTH];
  Vector::Operands  view  [DEPTH];
  logic [DEPTH-1:0] col   [DEPTH];  // col[j][i] = older_reg[i][j]
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] oldest;

  logic [EW-1:0] alloc_idx;
  logic [EW-1:0] sel_idx;
  logic          alloc_fire;
  logic          issue_fire;
  Vector::Operands in_opnd_woken;

  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign woken[gi] = wake(opnd_reg[gi], wb_valid, wb_ref, vcr_wb_valid);
`ifdef VRS_SAME_CYCLE_WAKEUP_EN
      assign view[gi] = woken[gi];
`else
      assign view[gi] = opnd_reg[gi];
`endif
      assign ready[gi] = busy_reg[gi]
                       & (~view[gi].required[0] | view[gi].valid[0])
                       & (~view[gi].required[1] | view[gi].valid[1])
                       & (~view[gi].require_vcr | view[gi].vcr_valid);
      for (gj = 0; gj < DEPTH; gj++) begin : g_col
        assign col[gi][gj] = older_reg[gj][gi];
      end
      // An entry is oldest-ready when no older entry is also ready.
      assign oldest[gi] = ready[gi] & ~|(ready & col[gi]);
    end
  endgenerate

  // Lowest-index free entry for the next dispatch.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) alloc_idx = EW'(i);
    end
  end

  // Encode the oldest ready entry; ages form a total order so one bit is set.
  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (oldest[i]) sel_idx = EW'(i);
    end
  end

  // Read out the selected entry.
  always_comb begin
    out_op   = '0;
    out_opnd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_idx == EW'(i)) begin
        out_op   = op_reg[i];
        out_opnd = view[i];
      end
    end
  end

  assign in_ready        = ~&busy_reg;
  assign out_valid       = |ready;
  assign alloc_fire      = in_valid & in_ready & ~flush;
  assign issue_fire      = out_valid & out_ready;
  assign in_opnd_woken   = wake(in_opnd, wb_valid, wb_ref, vcr_wb_valid);
  assign alloc_ref.unit  = UNIT_ID;
  assign alloc_ref.entry = alloc_idx;
  assign out_ref.unit    = UNIT_ID;
  assign out_ref.entry   = sel_idx;

  // Entry state: allocation with broadcast bypass, wakeup, issue, flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_reg[i] <= 1'b0;
        op_reg[i]   <= '0;
        opnd_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          busy_reg[i] <= 1'b0;
        end else if (alloc_fire && (alloc_idx == EW'(i))) begin
          busy_reg[i] <= 1'b1;
          op_reg[i]   <= in_op;
          opnd_reg[i] <= in_opnd_woken;
        end else begin
          if (issue_fire && (sel_idx == EW'(i))) busy_reg[i] <= 1'b0;
          if (busy_reg[i]) opnd_reg[i] <= woken[i];
        end
      end
    end
  end

  // Age matrix: new entry is younger than every surviving busy entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (issue_fire && ((sel_idx == EW'(i)) || (sel_idx == EW'(j))))
            older_reg[i][j] <= 1'b0;
          if (alloc_fire && (alloc_idx == EW'(j)))
            older_reg[i][j] <= busy_reg[i] & ~(issue_fire && (sel_idx == EW'(i)));
          if (alloc_fire && (alloc_idx == EW'(i)))
            older_reg[i][j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_rsv_station.sv
// Directed, table-driven bench for vector_rsv_station (default build).
// Each table row holds one cycle of inputs plus the outputs expected before
// the following clock edge; reset behaviour is checked by hand sequences.

module tb_vector_rsv_station;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  Vector::Vector_operation in_op;
  Vector::Operands         in_opnd;
  Vector::Rs_ref           alloc_ref;
  logic                    wb_valid;
  Vector::Rs_ref           wb_ref;
  logic                    vcr_wb_valid;
  logic                    out_valid;
  logic                    out_ready;
  Vector::Vector_operation out_op;
  Vector::Operands         out_opnd;
  Vector::Rs_ref           out_ref;

  vector_rsv_station #(
    .DEPTH   (4),
    .UNIT_ID (Vector::VU_ID_MADD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_opnd      (in_opnd),
    .alloc_ref    (alloc_ref),
    .wb_valid     (wb_valid),
    .wb_ref       (wb_ref),
    .vcr_wb_valid (vcr_wb_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_opnd     (out_opnd),
    .out_ref      (out_ref)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iv;
    logic [5:0] opc;
    logic [2:0] s0u;
    logic [3:0] s0e;
    logic [1:0] req;
    logic [1:0] vld;
    logic       rvcr;
    logic       vcrv;
    logic       wbv;
    logic [2:0] wbu;
    logic [3:0] wbe;
    logic       vcrw;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic [3:0] e_alloc;
    logic       e_ov;
    logic [3:0] e_ref;
    logic [5:0] e_opc;
    logic       e_v0;
  } vec_t;

  vec_t tbl [64];
  int   n_rows = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic iv, input logic [5:0] opc,
                     input logic [2:0] s0u, input logic [3:0] s0e,
                     input logic [1:0] req, input logic [1:0] vld,
                     input logic rvcr, input logic vcrv,
                     input logic wbv, input logic [2:0] wbu, input logic [3:0] wbe,
                     input logic vcrw, input logic ordy, input logic fl,
                     input logic e_ir, input logic [3:0] e_alloc,
                     input logic e_ov, input logic [3:0] e_ref,
                     input logic [5:0] e_opc, input logic e_v0);
    tbl[n_rows] = '{iv, opc, s0u, s0e, req, vld, rvcr, vcrv, wbv, wbu, wbe,
                    vcrw, ordy, fl, e_ir, e_alloc, e_ov, e_ref, e_opc, e_v0};
    n_rows++;
  endtask

  task automatic chk(input string nm, input int r, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, r, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    in_valid                   = t.iv;
    in_op                      = '0;
    in_op.opcode               = t.opc;
    in_opnd                    = '0;
    in_opnd.src_ref[0].unit    = Vector::Unit_id'(t.s0u);
    in_opnd.src_ref[0].entry   = t.s0e;
    in_opnd.src_ref[1].unit    = Vector::VU_ID_PERMUTE;
    in_opnd.src_ref[1].entry   = 4'd15;
    in_opnd.required           = t.req;
    in_opnd.valid              = t.vld;
    in_opnd.require_vcr        = t.rvcr;
    in_opnd.vcr_valid          = t.vcrv;
    wb_valid                   = t.wbv;
    wb_ref.unit                = Vector::Unit_id'(t.wbu);
    wb_ref.entry               = t.wbe;
    vcr_wb_valid               = t.vcrw;
    out_ready                  = t.ordy;
    flush                      = t.fl;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_op = '0; in_opnd = '0; wb_valid = 1'b0; wb_ref = '0;
    vcr_wb_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // iv opc u e req vld rv vv | wbv u e vcrw | ordy fl | ir alloc ov ref opc v0
    // Single ready op: allocate, issue, drain.
    add(1, 1, 0,0, 2'b11,2'b11,0,0, 0,0,0,0, 0,0, 1,0,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,1,1,0, 1,1);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 1,0,0,0, 0,0);
    // Three waiters on {MADD,5/6/7}; wake 7 then 5.
    add(1, 2, 0,5, 2'b01,2'b00,0,0, 0,0,0,0, 0,0, 1,0,0,0, 0,0);
    add(1, 3, 0,6, 2'b01,2'b00,0,0, 0,0,0,0, 0,0, 1,1,0,0, 0,0);
    add(1, 4, 0,7, 2'b01,2'b00,0,0, 0,0,0,0, 0,0, 1,2,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 1,0,7,0, 0,0, 1,3,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 1,0,5,0, 1,0, 1,3,1,2, 4,1);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,2,1,0, 2,1);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,0,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 1,0,6,0, 1,0, 1,0,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,0,1,1, 3,1);
    // Fill all four entries, reject a fifth, issue with age ordering.
    add(1, 5, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 1,0,0,0, 0,0);
    add(1, 6, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 1,1,1,0, 5,0);
    add(1, 7, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 1,2,1,0, 5,0);
    add(1, 8, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 1,3,1,0, 5,0);
    add(1, 9, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 0,0,1,0, 5,0);
    add(1, 9, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 0,0,1,0, 5,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 1,0,1,1, 6,0);
    add(1,10, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,0,1,1, 6,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,1,1,2, 7,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,1,1,3, 8,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,1,1,0,10,0);
    // Allocation bypass and unit-field compare.
    add(1,11, 1,3, 2'b01,2'b00,0,0, 1,1,3,0, 0,0, 1,0,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,1,1,0,11,1);
    add(1,12, 2,3, 2'b01,2'b00,0,0, 1,1,3,0, 0,0, 1,0,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 1,1,3,0, 1,0, 1,1,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 1,2,3,0, 0,0, 1,1,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,1,1,0,12,1);
    // VCR dependency; tag match on a non-required source is ignored.
    add(1,13, 0,0, 2'b11,2'b11,1,0, 0,0,0,0, 0,0, 1,0,0,0, 0,0);
    add(1,14, 0,9, 2'b00,2'b00,1,0, 0,0,0,0, 1,0, 1,1,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 1,0,9,0, 1,0, 1,2,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,2,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,1, 1,0, 1,2,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,2,1,0,13,1);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,0,1,1,14,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 1,0,0,0, 0,0);
    // Flush with dispatch and broadcast in the same cycle.
    add(1,15, 0,1, 2'b01,2'b00,0,0, 0,0,0,0, 0,0, 1,0,0,0, 0,0);
    add(1,16, 0,1, 2'b01,2'b00,0,0, 0,0,0,0, 0,0, 1,1,0,0, 0,0);
    add(1,17, 0,1, 2'b01,2'b00,0,0, 0,0,0,0, 0,0, 1,2,0,0, 0,0);
    add(1,18, 0,0, 2'b00,2'b00,0,0, 1,0,1,0, 0,1, 1,3,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 1,0, 1,0,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 1,0,1,0, 1,0, 1,0,0,0, 0,0);
    add(0, 0, 0,0, 2'b00,2'b00,0,0, 0,0,0,0, 0,0, 1,0,0,0, 0,0);

    // Reset state.
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", -1, in_ready, 1);
    chk("reset_out_valid", -1, out_valid, 0);
    chk("reset_alloc_entry", -1, alloc_ref.entry, 0);
    chk("reset_out_ref_entry", -1, out_ref.entry, 0);
    chk("alloc_unit", -1, alloc_ref.unit, Vector::VU_ID_MADD);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < n_rows; r++) begin
      apply(tbl[r]);
      @(negedge clk);
      $display("step %0d: in_ready=%0d alloc=%0d out_valid=%0d out_ref=%0d opcode=%0d",
               r, in_ready, alloc_ref.entry, out_valid, out_ref.entry, out_op.opcode);
      chk("in_ready", r, in_ready, tbl[r].e_ir);
      if (tbl[r].e_ir) chk("alloc_entry", r, alloc_ref.entry, tbl[r].e_alloc);
      chk("out_valid", r, out_valid, tbl[r].e_ov);
      if (tbl[r].e_ov) begin
        chk("out_ref_entry", r, out_ref.entry, tbl[r].e_ref);
        chk("out_ref_unit", r, out_ref.unit, Vector::VU_ID_MADD);
        chk("out_opcode", r, out_op.opcode, tbl[r].e_opc);
        chk("out_src0_valid", r, out_opnd.valid[0], tbl[r].e_v0);
      end
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a run.
    idle();
    in_valid = 1'b1;
    in_op.opcode = 6'd20;
    @(posedge clk); #1;
    in_op.opcode = 6'd21;
    @(posedge clk); #1;
    idle();
    #2;
    $display("pre-reset: out_valid=%0d in_ready=%0d alloc=%0d", out_valid, in_ready, alloc_ref.entry);
    chk("prereset_out_valid", -2, out_valid, 1);
    chk("prereset_alloc_entry", -2, alloc_ref.entry, 2);
    reset = 1'b1;
    #1;
    $display("mid-run reset: out_valid=%0d in_ready=%0d alloc=%0d", out_valid, in_ready, alloc_ref.entry);
    chk("async_reset_out_valid", -2, out_valid, 0);
    chk("async_reset_in_ready", -2, in_ready, 1);
    chk("async_reset_alloc_entry", -2, alloc_ref.entry, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_out_valid", -3, out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
